// File: rtl/fp32_vec_accum.sv
// Sequential FP32 accumulator: four cycles per element (capture, align, add, normalize).
// Zero/subnormal flush, truncating arithmetic, overflow saturates to infinity.
module fp32_vec_accum #(
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [31:0]      sum_data,
    output logic [CNT_W-1:0] sum_count
);

    typedef enum logic [2:0] {S_IN, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, b_q, spec_val_q;
    logic              last_q, spec_q, sgn_q, sub_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        exp_q;
    logic [23:0]       ml_q, ms_q;
    logic [24:0]       sum_q;

    logic              a_inf, b_inf, a_zero, b_zero, a_ge, spec_c;
    logic [31:0]       l_op, s_op, spec_val_c, norm_c;
    logic [7:0]        d, exp_inc, exp_sub;
    logic [23:0]       s_sh, diff;
    logic [22:0]       diff_sh;
    logic [4:0]        lz;
    logic              found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        sum_valid = 1'b0;
        unique case (state_q)
            S_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_ALIGN;
            end
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = last_q ? S_OUT : S_IN;
            S_OUT: begin
                sum_valid = 1'b1;
                if (sum_ready) state_d = S_IN;
            end
            default: state_d = S_IN;
        endcase
    end

    // Classification and magnitude ordering; specials bypass the adder.
    always_comb begin
        a_inf      = &acc_q[30:23];
        b_inf      = &b_q[30:23];
        a_zero     = ~|acc_q[30:23];
        b_zero     = ~|b_q[30:23];
        a_ge       = acc_q[30:0] >= b_q[30:0];
        l_op       = a_ge ? acc_q : b_q;
        s_op       = a_ge ? b_q : acc_q;
        d          = l_op[30:23] - s_op[30:23];
        s_sh       = (d >= 8'd24) ? 24'd0 : ({1'b1, s_op[22:0]} >> d);
        spec_c     = 1'b1;
        spec_val_c = 32'h0;
        if (b_inf)                spec_val_c = {b_q[31], 8'hff, 23'h0};
        else if (a_inf)           spec_val_c = {acc_q[31], 8'hff, 23'h0};
        else if (a_zero && b_zero) spec_val_c = 32'h0;
        else if (a_zero)          spec_val_c = b_q;
        else if (b_zero)          spec_val_c = acc_q;
        else                      spec_c = 1'b0;
    end

    always_comb begin
        diff  = sum_q[23:0];
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (diff[i]) found = 1'b1;
                else         lz = lz + 5'd1;
            end
        end
        diff_sh = diff[22:0] << lz;
        exp_inc = exp_q + 8'd1;
        exp_sub = exp_q - {3'b0, lz};
        norm_c  = 32'h0;
        if (spec_q) begin
            norm_c = spec_val_q;
        end else if (!sub_q) begin
            if (!sum_q[24])          norm_c = {sgn_q, exp_q, sum_q[22:0]};
            else if (&exp_inc)       norm_c = {sgn_q, 8'hff, 23'h0};
            else                     norm_c = {sgn_q, exp_inc, sum_q[23:1]};
        end else if (diff != 24'd0 && exp_q > {3'b0, lz}) begin
            norm_c = {sgn_q, exp_sub, diff_sh};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= 32'h0;
            b_q        <= 32'h0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'h0;
            sgn_q      <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= 8'h0;
            ml_q       <= 24'h0;
            ms_q       <= 24'h0;
            sum_q      <= 25'h0;
        end else begin
            unique case (state_q)
                S_IN: if (in_valid) begin
                    b_q    <= in_data;
                    last_q <= in_last || (cnt_q == CNT_W'(MAX_LEN - 1));
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                S_ALIGN: begin
                    spec_q     <= spec_c;
                    spec_val_q <= spec_val_c;
                    sgn_q      <= l_op[31];
                    sub_q      <= l_op[31] ^ s_op[31];
                    exp_q      <= l_op[30:23];
                    ml_q       <= {1'b1, l_op[22:0]};
                    ms_q       <= s_sh;
                end
                S_ADD: sum_q <= sub_q ? {1'b0, ml_q} - {1'b0, ms_q}
                                      : {1'b0, ml_q} + {1'b0, ms_q};
                S_NORM: acc_q <= norm_c;
                S_OUT: if (sum_ready) begin
                    acc_q <= 32'h0;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign sum_data  = acc_q;
    assign sum_count = cnt_q;

endmodule

// File: tb/tb_fp32_vec_accum.sv
// Randomized bench for fp32_vec_accum against an arithmetic reference model.
// Runs with MAX_LEN=4 so automatic vector closing is exercised often.
module tb_fp32_vec_accum;

    localparam int ML = 4;
    localparam int CW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'h0;
    logic          in_last = 1'b0;
    logic          sum_valid;
    logic          sum_ready = 1'b0;
    logic [31:0]   sum_data;
    logic [CW-1:0] sum_count;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   m_acc = 32'h0;
    int            m_cnt = 0;
    bit            closed;

    fp32_vec_accum #(.MAX_LEN(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data), .sum_count(sum_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b);
        int          ea, eb, el, es, e;
        longint      ml, ms, s;
        logic        sl, ss;
        logic [31:0] r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (eb == 255) return {b[31], 8'hff, 23'h0};
        if (ea == 255) return {a[31], 8'hff, 23'h0};
        if (ea == 0 && eb == 0) return 32'h0;
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (a[30:0] >= b[30:0]) begin
            sl = a[31]; ss = b[31]; el = ea; es = eb;
            ml = longint'(a[22:0]) + 64'd8388608;
            ms = longint'(b[22:0]) + 64'd8388608;
        end else begin
            sl = b[31]; ss = a[31]; el = eb; es = ea;
            ml = longint'(b[22:0]) + 64'd8388608;
            ms = longint'(a[22:0]) + 64'd8388608;
        end
        ms = (el - es >= 24) ? 0 : ms / (64'd1 << (el - es));
        e  = el;
        if (sl == ss) begin
            s = ml + ms;
            if (s >= 64'd16777216) begin
                s = s / 2;
                e++;
            end
            if (e >= 255) return {sl, 8'hff, 23'h0};
        end else begin
            s = ml - ms;
            if (s == 0) return 32'h0;
            while (s < 64'd8388608) begin
                s = s * 2;
                e--;
            end
            if (e <= 0) return 32'h0;
        end
        r = {sl, e[7:0], s[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] gen_elem();
        int k;
        k = int'($urandom_range(0, 19));
        if (k == 0) return {1'b0, 8'h00, 23'($urandom)};
        if (k == 1) return {1'($urandom), 8'hff, 23'($urandom)};
        if (k == 2) return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
        return {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
    endfunction

    task automatic push(input logic [31:0] d, input logic l);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready_drop", 32'(in_ready), 32'd0);
    endtask

    task automatic feed(input logic [31:0] d, input logic l, output bit done);
        push(d, l);
        m_acc = ref_add(m_acc, d);
        m_cnt++;
        done = l || (m_cnt == ML);
    endtask

    task automatic get_sum(input string tag, input logic [31:0] exp_d,
                           input int exp_c, input int hold);
        int lat = 1;
        while (!sum_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_data"}, sum_data, exp_d);
        check({tag, "_count"}, 32'(sum_count), 32'(exp_c));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            check({tag, "_hold_data"}, sum_data, exp_d);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
        m_acc = 32'h0;
        m_cnt = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        check({tag, "_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_data"}, sum_data, 32'h0);
        check({tag, "_count"}, 32'(sum_count), 32'd0);
    endtask

    initial begin
        #1;
        check_reset_state("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        feed(32'h3F800000, 1'b0, closed);
        feed(32'h40000000, 1'b0, closed);
        feed(32'h40400000, 1'b1, closed);
        get_sum("six", 32'h40C00000, 3, 0);

        feed(32'h40400000, 1'b0, closed);
        feed(32'hC0400000, 1'b1, closed);
        get_sum("cancel", 32'h00000000, 2, 1);
        feed(32'h3F800000, 1'b0, closed);
        feed(32'h33800000, 1'b1, closed);
        get_sum("trunc_d24", 32'h3F800000, 2, 0);

        feed(32'h7F7FFFFF, 1'b0, closed);
        feed(32'h7F7FFFFF, 1'b0, closed);
        feed(32'hBF800000, 1'b1, closed);
        get_sum("ovf_sticky", 32'h7F800000, 3, 0);
        feed(32'h00000001, 1'b0, closed);
        feed(32'h3F800000, 1'b1, closed);
        get_sum("subn_flush", 32'h3F800000, 2, 0);

        feed(32'h00000005, 1'b1, closed);
        get_sum("single_zero", 32'h00000000, 1, 0);
        feed(32'hC1200000, 1'b1, closed);
        get_sum("single_neg", 32'hC1200000, 1, 0);

        feed(32'h3F800000, 1'b0, closed);
        feed(32'h3F800000, 1'b1, closed);
        get_sum("backpressure", 32'h40000000, 2, 10);
        feed(32'h40400000, 1'b0, closed);
        feed(32'h3F800000, 1'b1, closed);
        get_sum("after_bp", 32'h40800000, 2, 0);

        for (int i = 0; i < 6; i++) begin
            feed(32'h3F800000, 1'b0, closed);
            if (closed) get_sum("maxlen", 32'h40800000, 4, 0);
        end
        feed(32'h3F800000, 1'b1, closed);
        get_sum("maxlen_rest", 32'h40400000, 3, 0);

        feed(32'h3F800000, 1'b0, closed);
        feed(32'h40000000, 1'b0, closed);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 32'h0;
        m_cnt = 0;
        @(negedge clk);
        feed(32'h40000000, 1'b0, closed);
        feed(32'h40000000, 1'b0, closed);
        feed(32'h40000000, 1'b1, closed);
        get_sum("after_rst", 32'h40C00000, 3, 0);

        for (int v = 0; v < 60; v++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                feed(gen_elem(), 1'(j == len - 1), closed);
                if (closed)
                    get_sum("rnd", m_acc, m_cnt, int'($urandom_range(0, 3)));
                else if ($urandom_range(0, 3) == 0)
                    @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp32_vec_accum.md
# fp32_vec_accum

Sequential FP32 vector accumulator that sits directly downstream of the FP32 multiplier in the SoftMax datapath. It consumes a stream of single-precision products (or exponentials) and returns their running sum when the last element of a vector arrives. The sum serves as the SoftMax denominator and as the dot-product reduction stage. Its arithmetic conventions match the multiplier: zero or subnormal inputs flush to zero, results truncate with no rounding, and overflow saturates to infinity.

## Interface
- `MAX_LEN`, default 1024: maximum elements per vector. When the count reaches `MAX_LEN`, the block closes the vector as if `in_last` were asserted.
- `CNT_W`, default `$clog2(MAX_LEN+1)`: width of the element counter.

Ports:
- `clk`  input  1  : single clock. All logic is on the rising edge.
- `rst_n`  input  1  : asynchronous, active-low reset.
- `in_valid`  input  1  : an input element is present.
- `in_ready`  output  1  : the block accepts an element this cycle.
- `in_data`  input  32  : FP32 element.
- `in_last`  input  1  : this element is the final one of the vector.
- `sum_valid`  output  1  : the result is available. It holds until accepted.
- `sum_ready`  input  1  : the consumer accepts the result.
- `sum_data`  output  32  : accumulated FP32 sum.
- `sum_count`  output  CNT_W  : number of elements summed into `sum_data`.

## Operation
FSM states:
- **S_IN**: `in_ready`=1. On `in_valid`, latch `in_data`, latch last as `in_last` OR (count+1==`MAX_LEN`), increment count, then go to S_ALIGN.
- **S_ALIGN**: classify the operands, order them by magnitude, and align, then go to S_ADD.
- **S_ADD**: add or subtract the mantissas, then go to S_NORM.
- **S_NORM**: normalize and write the accumulator. Go to S_OUT if last, else S_IN.
- **S_OUT**: `sum_valid`=1. On `sum_ready`, clear the accumulator to +0 and the count to 0, then go to S_IN.

Every element takes exactly the four-state path, even when the add is trivial.

Arithmetic rules:
- Operand A is the accumulator, operand B is the latched input.
- Zero: exp==0 means zero. The mantissa is ignored, so subnormals flush. The accumulator resets to +0.
- Infinity: exp==255 means infinity. If either operand is infinity, the result is infinity with the sign of that operand. If both are infinity, the input's sign wins. NaN is not distinguished: any exp==255 is treated as infinity, and the mantissa is forced to 0.
- Zero operands: if one operand is zero, the result is the other operand unchanged. If both are zero, the result is +0.
- Ordering: the larger of {exp,mant} is L and the other is S, each with the hidden 1 making a 24-bit mantissa. d = expL − expS. S is shifted right by d and the shifted-out bits are discarded. If d ≥ 24, S becomes 0.
- Same sign: sum = L + S (25 bits). If bit 24 is set, shift right by 1 (truncate) and increment exp. If exp reaches 255, the result is infinity.
- Opposite sign: diff = L − S. If diff==0, the result is +0. Otherwise shift left by the leading-zero count lz and subtract lz from exp. If exp−lz ≤ 0, the result is +0.
- Result sign is the sign of L.
- Once the accumulator is infinity, it stays infinity for the rest of the vector.

## Timing
- Reset values:
  - state S_IN
  - `in_ready`=1
  - `sum_valid`=0
  - `sum_data`=32'h0
  - `sum_count`=0
  - accumulator +0
- An input handshake completes on the cycle where `in_valid`&&`in_ready`. `in_ready` falls the next cycle and returns 4 cycles after the accept.
- Maximum throughput is one element per 4 cycles.
- Latency: if the last element is accepted at edge t, `sum_valid` rises after edge t+3 and is visible in cycle t+4.
- `sum_data` and `sum_count` are stable while `sum_valid`=1.
- Output handshake:
  - `in_ready`=0 throughout S_OUT.
  - The output handshake completes when `sum_valid`&&`sum_ready`. S_IN and `in_ready`=1 follow on the next cycle.
- `sum_valid` does not depend combinationally on `sum_ready`.
- `in_last` is sampled only with an accepted element.
- A single-element vector returns that element, or +0 if it is a zero or subnormal.
- Reset asserted mid-vector or in S_OUT immediately returns all state to the reset values. The partial sum is lost.

## Test plan
- Accept 3F800000, 40000000, then 40400000 with last → `sum_data`=40C00000 (6.0), `sum_count`=3, `sum_valid` visible 4 cycles after the last accept.
- Accept 40400000, then C0400000 with last → 00000000. Also accept 3F800000, then 33800000 (2^-24) with last → 3F800000 (truncation, d=24).
- Accept 7F7FFFFF, then 7F7FFFFF, then BF800000 with last → 7F800000 (sticky overflow). Accept 00000001, then 3F800000 with last → 3F800000 (subnormal flush).
- Hold `sum_ready`=0 for 10 cycles with `in_valid`=1 → `sum_data` stays stable and `in_ready` stays 0. Release `sum_ready` → the next vector starts from +0 and gives an independent correct sum.
- Use `MAX_LEN`=4 and feed 6 elements of 3F800000 with no `in_last` → first sum 40800000 with count 4, second vector holds 2 elements so far.
- Assert `rst_n` low after 2 of 3 elements → outputs return to reset values. A fresh 3-element vector then sums correctly.
